// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_pkg
//  Description : Shared widths, response codes and FSM encodings for the
//                AXI4-Lite SRAM slave and the interconnect that talks to it.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi4_lite_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int STRB_W = 8;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } rd_state_t;

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/axi4_lite_sram_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_sram_slave_if
//  Description : AXI4-Lite read/write channel bundle with master and slave
//                views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi4_lite_sram_slave_if;
  import axi4_lite_pkg::*;

  logic [ADDR_W-1:0] AR_ADDR;
  logic              AR_VALID;
  logic [2:0]        AR_PROT;
  logic              AR_READY;
  logic [DATA_W-1:0] R_DATA;
  logic              R_RESP;
  logic              R_VALID;
  logic              R_READY;
  logic [ADDR_W-1:0] AW_ADDR;
  logic              AW_VALID;
  logic [2:0]        AW_PORT;
  logic              AW_READY;
  logic [DATA_W-1:0] W_DATA;
  logic [STRB_W-1:0] W_STRB;
  logic              W_VALID;
  logic              W_READY;
  logic              B_RESP;
  logic              B_VALID;
  logic              B_READY;

  modport slave (
    input  AR_ADDR, AR_VALID, AR_PROT, R_READY,
    input  AW_ADDR, AW_VALID, AW_PORT, W_DATA, W_STRB, W_VALID, B_READY,
    output AR_READY, R_DATA, R_RESP, R_VALID,
    output AW_READY, W_READY, B_RESP, B_VALID
  );

  modport master (
    output AR_ADDR, AR_VALID, AR_PROT, R_READY,
    output AW_ADDR, AW_VALID, AW_PORT, W_DATA, W_STRB, W_VALID, B_READY,
    input  AR_READY, R_DATA, R_RESP, R_VALID,
    input  AW_READY, W_READY, B_RESP, B_VALID
  );

endinterface
`default_nettype wire

// File: rtl/axi4_lite_sram_array.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_sram_array
//  Description : Word storage organised as byte lanes: one byte-enabled
//                synchronous write port, one combinational read port.
//                Contents are deliberately not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_sram_array
  import axi4_lite_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  wire logic              clk,
  input  wire logic              we_i,
  input  wire logic [IDX_W-1:0]  waddr_i,
  input  wire logic [DATA_W-1:0] wdata_i,
  input  wire logic [STRB_W-1:0] wstrb_i,
  input  wire logic [IDX_W-1:0]  raddr_i,
  output logic      [DATA_W-1:0] rdata_o
);

  for (genvar g = 0; g < STRB_W; g++) begin : g_lane
    logic [7:0] lane_q [DEPTH_WORDS];

    // Byte lane write, gated by its own strobe bit
    always_ff @(posedge clk) begin
      if (we_i && wstrb_i[g]) begin
        lane_q[waddr_i] <= wdata_i[8*g +: 8];
      end
    end

    assign rdata_o[8*g +: 8] = lane_q[raddr_i];
  end

endmodule
`default_nettype wire

// File: rtl/axi4_lite_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_sram_slave
//  Description : AXI4-Lite slave in front of a 64-bit SRAM. Independent read
//                and write FSMs, programmable read latency, out-of-range
//                accesses answered with an error response.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_sram_slave
  import axi4_lite_pkg::*;
#(
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 64'h8000_0000,
  parameter int                RD_LATENCY  = 1
) (
  input wire logic             clk,
  input wire logic             rst_n,
  axi4_lite_sram_slave_if.slave bus
);

  localparam int                c_idx_w  = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] c_span   = ADDR_W'(DEPTH_WORDS) << 3;
  localparam logic [3:0]        c_lat_m1 = 4'(RD_LATENCY - 1);

  // Ready outputs stay low until the first edge after reset release
  logic active_q;

  rd_state_t         rd_state_q, rd_state_d;
  logic [3:0]        rd_cnt_q,   rd_cnt_d;
  logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
  logic [DATA_W-1:0] r_data_q,   r_data_d;
  logic              r_resp_q,   r_resp_d;

  wr_state_t         wr_state_q, wr_state_d;
  logic              aw_got_q,   aw_got_d;
  logic              w_got_q,    w_got_d;
  logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,  wr_data_d;
  logic [STRB_W-1:0] wr_strb_q,  wr_strb_d;
  logic              b_resp_q,   b_resp_d;

  logic              w_ar_hs, w_aw_hs, w_w_hs;
  logic [ADDR_W-1:0] w_rd_addr, w_rd_off;
  logic              w_rd_ok;
  logic [DATA_W-1:0] w_rd_word;
  logic [ADDR_W-1:0] w_wr_addr, w_wr_off;
  logic [DATA_W-1:0] w_wr_data;
  logic [STRB_W-1:0] w_wr_strb;
  logic              w_wr_ok, w_commit, w_we;
  logic              unused_prot;

  assign unused_prot = ^{bus.AR_PROT, bus.AW_PORT};

  assign bus.AR_READY = active_q & (rd_state_q == RD_IDLE);
  assign bus.R_VALID  = (rd_state_q == RD_RESP);
  assign bus.R_DATA   = r_data_q;
  assign bus.R_RESP   = r_resp_q;
  assign bus.AW_READY = active_q & (wr_state_q == WR_IDLE) & ~aw_got_q;
  assign bus.W_READY  = active_q & (wr_state_q == WR_IDLE) & ~w_got_q;
  assign bus.B_VALID  = (wr_state_q == WR_RESP);
  assign bus.B_RESP   = b_resp_q;

  assign w_ar_hs = bus.AR_VALID & bus.AR_READY;
  assign w_aw_hs = bus.AW_VALID & bus.AW_READY;
  assign w_w_hs  = bus.W_VALID  & bus.W_READY;

  // With latency 1 the capture happens on the handshake edge itself, so the
  // read port looks at the live address while idle
  assign w_rd_addr = (rd_state_q == RD_IDLE) ? bus.AR_ADDR : rd_addr_q;
  assign w_rd_off  = w_rd_addr - BASE_ADDR;
  assign w_rd_ok   = (w_rd_addr >= BASE_ADDR) && (w_rd_off < c_span);

  // Address and data may each come from the held copy or the live channel
  assign w_wr_addr = aw_got_q ? wr_addr_q : bus.AW_ADDR;
  assign w_wr_data = w_got_q  ? wr_data_q : bus.W_DATA;
  assign w_wr_strb = w_got_q  ? wr_strb_q : bus.W_STRB;
  assign w_wr_off  = w_wr_addr - BASE_ADDR;
  assign w_wr_ok   = (w_wr_addr >= BASE_ADDR) && (w_wr_off < c_span);
  assign w_commit  = (wr_state_q == WR_IDLE) & (aw_got_q | w_aw_hs) & (w_got_q | w_w_hs);
  assign w_we      = w_commit & w_wr_ok;

  axi4_lite_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (c_idx_w)
  ) u_array (
    .clk     (clk),
    .we_i    (w_we),
    .waddr_i (w_wr_off[c_idx_w+2:3]),
    .wdata_i (w_wr_data),
    .wstrb_i (w_wr_strb),
    .raddr_i (w_rd_off[c_idx_w+2:3]),
    .rdata_o (w_rd_word)
  );

  // Read channel next-state: accept, count down latency, hold response
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_addr_d  = rd_addr_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (w_ar_hs) begin
          rd_addr_d = bus.AR_ADDR;
          rd_cnt_d  = c_lat_m1;
          if (c_lat_m1 == 4'd0) begin
            rd_state_d = RD_RESP;
            r_data_d   = w_rd_ok ? w_rd_word : '0;
            r_resp_d   = w_rd_ok ? RESP_OKAY : RESP_ERR;
          end else begin
            rd_state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        rd_cnt_d = rd_cnt_q - 4'd1;
        if (rd_cnt_q == 4'd1) begin
          rd_state_d = RD_RESP;
          r_data_d   = w_rd_ok ? w_rd_word : '0;
          r_resp_d   = w_rd_ok ? RESP_OKAY : RESP_ERR;
        end
      end
      RD_RESP: begin
        if (bus.R_READY) begin
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Write channel next-state: collect AW and W in any order, commit, respond
  always_comb begin
    wr_state_d = wr_state_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
    b_resp_d   = b_resp_q;
    unique case (wr_state_q)
      WR_IDLE: begin
        if (w_aw_hs) begin
          aw_got_d  = 1'b1;
          wr_addr_d = bus.AW_ADDR;
        end
        if (w_w_hs) begin
          w_got_d   = 1'b1;
          wr_data_d = bus.W_DATA;
          wr_strb_d = bus.W_STRB;
        end
        if (w_commit) begin
          wr_state_d = WR_RESP;
          b_resp_d   = w_wr_ok ? RESP_OKAY : RESP_ERR;
        end
      end
      WR_RESP: begin
        if (bus.B_READY) begin
          wr_state_d = WR_IDLE;
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      rd_state_q <= RD_IDLE;
      rd_cnt_q   <= '0;
      rd_addr_q  <= '0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
      wr_state_q <= WR_IDLE;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      b_resp_q   <= RESP_OKAY;
    end else begin
      active_q   <= 1'b1;
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_addr_q  <= rd_addr_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      wr_state_q <= wr_state_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      b_resp_q   <= b_resp_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_lite_sram_slave
//  Description : Directed self-checking bench. A latency-1 slave is driven
//                directly; a latency-4 slave shares its write channel and
//                read address so both memories hold identical contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_sram_slave;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  axi4_lite_sram_slave_if bus  ();
  axi4_lite_sram_slave_if bus4 ();

  always #5 clk = ~clk;

  assign bus4.AR_ADDR  = bus.AR_ADDR;
  assign bus4.AR_PROT  = bus.AR_PROT;
  assign bus4.AW_ADDR  = bus.AW_ADDR;
  assign bus4.AW_VALID = bus.AW_VALID;
  assign bus4.AW_PORT  = bus.AW_PORT;
  assign bus4.W_DATA   = bus.W_DATA;
  assign bus4.W_STRB   = bus.W_STRB;
  assign bus4.W_VALID  = bus.W_VALID;
  assign bus4.B_READY  = bus.B_READY;

  axi4_lite_sram_slave #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (64'h8000_0000),
    .RD_LATENCY  (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  axi4_lite_sram_slave #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (64'h8000_0000),
    .RD_LATENCY  (4)
  ) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, output logic resp);
    int   n;
    logic aw_done, w_done, aw_hs, w_hs;
    bus.AW_ADDR  = addr;
    bus.AW_VALID = 1'b1;
    bus.W_DATA   = data;
    bus.W_STRB   = strb;
    bus.W_VALID  = 1'b1;
    bus.B_READY  = 1'b1;
    aw_done = 1'b0;
    w_done  = 1'b0;
    n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = bus.AW_VALID && bus.AW_READY;
      w_hs  = bus.W_VALID && bus.W_READY;
      step();
      if (aw_hs) begin aw_done = 1'b1; bus.AW_VALID = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; bus.W_VALID  = 1'b0; end
      n++;
    end
    chk("wr_accept", {62'd0, aw_done, w_done}, 64'd3);
    bus.AW_VALID = 1'b0;
    bus.W_VALID  = 1'b0;
    n = 0;
    while (!bus.B_VALID && n < 20) begin step(); n++; end
    chk("wr_bvalid", {63'd0, bus.B_VALID}, 64'd1);
    resp = bus.B_RESP;
    step();
  endtask

  task automatic do_read(input logic [63:0] addr, output logic [63:0] data, output logic resp);
    int n;
    bus.AR_ADDR  = addr;
    bus.AR_VALID = 1'b1;
    bus.R_READY  = 1'b1;
    n = 0;
    while (!bus.AR_READY && n < 20) begin step(); n++; end
    chk("rd_arready", {63'd0, bus.AR_READY}, 64'd1);
    step();
    bus.AR_VALID = 1'b0;
    n = 0;
    while (!bus.R_VALID && n < 20) begin step(); n++; end
    chk("rd_rvalid", {63'd0, bus.R_VALID}, 64'd1);
    data = bus.R_DATA;
    resp = bus.R_RESP;
    step();
    bus.R_READY = 1'b0;
  endtask

  initial begin
    logic [63:0] d;
    logic        r;
    logic [63:0] held;

    rst_n         = 1'b0;
    bus.AR_ADDR   = '0;
    bus.AR_VALID  = 1'b0;
    bus.AR_PROT   = 3'b101;
    bus.R_READY   = 1'b0;
    bus.AW_ADDR   = '0;
    bus.AW_VALID  = 1'b0;
    bus.AW_PORT   = 3'b010;
    bus.W_DATA    = '0;
    bus.W_STRB    = '0;
    bus.W_VALID   = 1'b0;
    bus.B_READY   = 1'b0;
    bus4.AR_VALID = 1'b0;
    bus4.R_READY  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", {63'd0, bus.AR_READY}, 64'd0);
    chk("rst_awready", {63'd0, bus.AW_READY}, 64'd0);
    chk("rst_wready",  {63'd0, bus.W_READY},  64'd0);
    chk("rst_rvalid",  {63'd0, bus.R_VALID},  64'd0);
    chk("rst_bvalid",  {63'd0, bus.B_VALID},  64'd0);
    chk("rst_rdata",   bus.R_DATA, 64'd0);
    rst_n = 1'b1;
    chk("rel_arready_pre", {63'd0, bus.AR_READY}, 64'd0);
    step();
    chk("rel_arready", {63'd0, bus.AR_READY}, 64'd1);
    chk("rel_awready", {63'd0, bus.AW_READY}, 64'd1);
    chk("rel_wready",  {63'd0, bus.W_READY},  64'd1);

    // Full-word write, AW and W in the same cycle
    bus.AW_ADDR  = 64'h8000_0008;
    bus.AW_VALID = 1'b1;
    bus.W_DATA   = 64'h1122_3344_5566_7788;
    bus.W_STRB   = 8'hFF;
    bus.W_VALID  = 1'b1;
    bus.B_READY  = 1'b1;
    step();
    bus.AW_VALID = 1'b0;
    bus.W_VALID  = 1'b0;
    chk("b_valid_after_commit", {63'd0, bus.B_VALID}, 64'd1);
    chk("b_resp_ok", {63'd0, bus.B_RESP}, 64'd0);
    chk("aw_ready_in_resp", {63'd0, bus.AW_READY}, 64'd0);
    step();
    chk("b_valid_cleared", {63'd0, bus.B_VALID}, 64'd0);
    chk("aw_ready_back", {63'd0, bus.AW_READY}, 64'd1);
    do_read(64'h8000_0008, d, r);
    chk("rd_full_word", d, 64'h1122_3344_5566_7788);
    chk("rd_full_resp", {63'd0, r}, 64'd0);
    do_read(64'h8000_000D, d, r);
    chk("rd_low_bits_ignored", d, 64'h1122_3344_5566_7788);

    // W three cycles ahead of AW, low-half strobe
    bus.W_DATA  = 64'hAAAA_AAAA_AAAA_AAAA;
    bus.W_STRB  = 8'h0F;
    bus.W_VALID = 1'b1;
    step();
    bus.W_VALID = 1'b0;
    chk("w_ready_held", {63'd0, bus.W_READY}, 64'd0);
    chk("aw_ready_wfirst", {63'd0, bus.AW_READY}, 64'd1);
    chk("no_bvalid_w_only", {63'd0, bus.B_VALID}, 64'd0);
    step();
    step();
    bus.AW_ADDR  = 64'h8000_0008;
    bus.AW_VALID = 1'b1;
    step();
    bus.AW_VALID = 1'b0;
    chk("b_valid_wfirst", {63'd0, bus.B_VALID}, 64'd1);
    step();
    do_read(64'h8000_0008, d, r);
    chk("rd_strb_low", d, 64'h1122_3344_AAAA_AAAA);

    // AW ahead of W, sparse strobe on outer bytes
    do_write(64'h8000_0018, 64'h0123_4567_89AB_CDEF, 8'hFF, r);
    bus.AW_ADDR  = 64'h8000_0018;
    bus.AW_VALID = 1'b1;
    step();
    bus.AW_VALID = 1'b0;
    chk("aw_ready_held", {63'd0, bus.AW_READY}, 64'd0);
    chk("w_ready_awfirst", {63'd0, bus.W_READY}, 64'd1);
    step();
    bus.W_DATA  = 64'hFF00_0000_0000_00EE;
    bus.W_STRB  = 8'h81;
    bus.W_VALID = 1'b1;
    step();
    bus.W_VALID = 1'b0;
    chk("b_valid_awfirst", {63'd0, bus.B_VALID}, 64'd1);
    step();
    do_read(64'h8000_0018, d, r);
    chk("rd_strb_81", d, 64'hFF23_4567_89AB_CDEE);

    // Range boundaries
    do_write(64'h8000_0000, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, r);
    chk("wr_word0_resp", {63'd0, r}, 64'd0);
    do_write(64'h8000_1FF8, 64'h0F1E_2D3C_4B5A_6978, 8'hFF, r);
    chk("wr_last_resp", {63'd0, r}, 64'd0);
    do_read(64'h7FFF_FFF8, d, r);
    chk("rd_below_data", d, 64'd0);
    chk("rd_below_resp", {63'd0, r}, 64'd1);
    do_write(64'h8000_2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, r);
    chk("wr_above_resp", {63'd0, r}, 64'd1);
    do_read(64'h8000_2000, d, r);
    chk("rd_above_resp", {63'd0, r}, 64'd1);
    do_read(64'h8000_0000, d, r);
    chk("rd_word0_unchanged", d, 64'h5A5A_5A5A_5A5A_5A5A);
    do_read(64'h8000_1FF8, d, r);
    chk("rd_last_word", d, 64'h0F1E_2D3C_4B5A_6978);
    chk("rd_last_resp", {63'd0, r}, 64'd0);

    // Read capture and write commit on the same edge, same word
    do_write(64'h8000_0010, 64'h0101_0101_0101_0101, 8'hFF, r);
    bus.AR_ADDR  = 64'h8000_0010;
    bus.AR_VALID = 1'b1;
    bus.R_READY  = 1'b0;
    bus.AW_ADDR  = 64'h8000_0010;
    bus.AW_VALID = 1'b1;
    bus.W_DATA   = 64'h0202_0202_0202_0202;
    bus.W_STRB   = 8'hFF;
    bus.W_VALID  = 1'b1;
    bus.B_READY  = 1'b0;
    step();
    bus.AR_VALID = 1'b0;
    bus.AW_VALID = 1'b0;
    bus.W_VALID  = 1'b0;
    chk("same_edge_rvalid", {63'd0, bus.R_VALID}, 64'd1);
    chk("same_edge_old_data", bus.R_DATA, 64'h0101_0101_0101_0101);
    chk("same_edge_bvalid", {63'd0, bus.B_VALID}, 64'd1);
    bus.R_READY = 1'b1;
    bus.B_READY = 1'b1;
    step();
    bus.R_READY = 1'b0;
    chk("same_edge_r_done", {63'd0, bus.R_VALID}, 64'd0);
    chk("same_edge_b_done", {63'd0, bus.B_VALID}, 64'd0);
    do_read(64'h8000_0010, d, r);
    chk("same_edge_new_data", d, 64'h0202_0202_0202_0202);

    // Latency 4: R_VALID first high four edges after the handshake
    bus.AR_ADDR   = 64'h8000_0008;
    bus4.AR_VALID = 1'b1;
    bus4.R_READY  = 1'b0;
    chk("l4_arready", {63'd0, bus4.AR_READY}, 64'd1);
    step();
    bus4.AR_VALID = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk("l4_rvalid_early", {63'd0, bus4.R_VALID}, 64'd0);
      step();
    end
    chk("l4_rvalid_c4", {63'd0, bus4.R_VALID}, 64'd1);
    chk("l4_rdata", bus4.R_DATA, 64'h1122_3344_AAAA_AAAA);
    chk("l4_rresp", {63'd0, bus4.R_RESP}, 64'd0);
    held = bus4.R_DATA;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("l4_hold_rvalid", {63'd0, bus4.R_VALID}, 64'd1);
      chk("l4_hold_rdata", bus4.R_DATA, held);
      chk("l4_hold_arready", {63'd0, bus4.AR_READY}, 64'd0);
    end
    bus4.R_READY = 1'b1;
    step();
    bus4.R_READY = 1'b0;
    chk("l4_rvalid_done", {63'd0, bus4.R_VALID}, 64'd0);
    chk("l4_arready_back", {63'd0, bus4.AR_READY}, 64'd1);

    // Reset during RD_WAIT with a half-captured write pending
    bus.W_DATA    = 64'hCCCC_CCCC_CCCC_CCCC;
    bus.W_STRB    = 8'hFF;
    bus.W_VALID   = 1'b1;
    bus4.AR_VALID = 1'b1;
    step();
    bus.W_VALID   = 1'b0;
    bus4.AR_VALID = 1'b0;
    step();
    chk("pre_rst_w_got", {63'd0, bus.W_READY}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("in_rst_arready4", {63'd0, bus4.AR_READY}, 64'd0);
    chk("in_rst_rvalid4", {63'd0, bus4.R_VALID}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_rst_arready_pre", {63'd0, bus4.AR_READY}, 64'd0);
    step();
    chk("post_rst_arready", {63'd0, bus4.AR_READY}, 64'd1);
    chk("post_rst_wready", {63'd0, bus.W_READY}, 64'd1);
    chk("post_rst_awready", {63'd0, bus.AW_READY}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_no_rvalid", {63'd0, bus4.R_VALID}, 64'd0);
      step();
    end
    do_read(64'h8000_0008, d, r);
    chk("storage_kept", d, 64'h1122_3344_AAAA_AAAA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi4_lite_sram_slave.md
AXI4_LITE_SRAM_SLAVE -- requirements
Module: axi4_lite_sram_slave

Interface
REQ-001 DEPTH_WORDS, 1024, number of 64-bit storage words (power of two).
REQ-002 BASE_ADDR, 64'h8000_0000, byte address of word 0.
REQ-003 RD_LATENCY, 1, cycles from AR handshake edge to R_VALID high (legal 1..15).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 AR_ADDR  input  64  read byte address.
REQ-007 AR_VALID  input  1  read address valid.
REQ-008 AR_PROT  input  3  ignored.
REQ-009 AR_READY  output  1  read address accepted.
REQ-010 R_DATA  output  64  read data.
REQ-011 R_RESP  output  1  0 = OKAY, 1 = error.
REQ-012 R_VALID  output  1  read data valid.
REQ-013 R_READY  input  1  master accepts read data.
REQ-014 AW_ADDR  input  64  write byte address.
REQ-015 AW_VALID  input  1  write address valid.
REQ-016 AW_PORT  input  3  ignored.
REQ-017 AW_READY  output  1  write address accepted.
REQ-018 W_DATA  input  64  write data.
REQ-019 W_STRB  input  8  byte enables; bit i covers W_DATA[8i+7:8i].
REQ-020 W_VALID  input  1  write data valid.
REQ-021 W_READY  output  1  write data accepted.
REQ-022 B_RESP  output  1  0 = OKAY, 1 = error.
REQ-023 B_VALID  output  1  write response valid.
REQ-024 B_READY  input  1  master accepts write response.

Function
REQ-025 Decode: in range iff BASE_ADDR <= addr < BASE_ADDR + 8*DEPTH_WORDS; index = (addr - BASE_ADDR) >> 3; addr[2:0] ignored.
REQ-026 Read FSM states RD_IDLE, RD_WAIT, RD_RESP; AR_READY = 1 only in RD_IDLE (after reset release, REQ-034).
REQ-027 AR_VALID & AR_READY latches address, loads counter with RD_LATENCY-1; next state RD_RESP if counter value 0, else RD_WAIT.
REQ-028 RD_WAIT decrements counter each cycle; moves to RD_RESP on the edge where counter == 1; R_DATA/R_RESP captured on the edge entering RD_RESP.
REQ-029 RD_RESP: R_VALID = 1, R_DATA and R_RESP held stable until R_VALID & R_READY, then RD_IDLE; next AR accepted no earlier than the following cycle.
REQ-030 Write FSM states WR_IDLE, WR_RESP with flags aw_got, w_got; in WR_IDLE AW_READY = !aw_got, W_READY = !w_got; AW and W accepted in either order or in the same cycle.
REQ-031 Commit on the edge where both address and data are held or arriving: write bytes with W_STRB[i] = 1 only, enter WR_RESP; B_VALID = 1 until B_VALID & B_READY, then clear flags, return to WR_IDLE.
REQ-032 Out of range: read returns R_DATA = 0, R_RESP = 1; write changes no storage, B_RESP = 1; otherwise RESP = 0.
REQ-033 Read and write channels operate concurrently; a read capture on the same edge as a commit to the same word returns pre-write data.

Reset
REQ-034 While rst_n = 0: all outputs 0, FSMs idle, counter and flags cleared; AR_READY/AW_READY/W_READY go high on the first edge after release.
REQ-035 Reset mid-transaction abandons it: no response issued, a half-captured write is discarded, storage contents not reset.

Structure
REQ-036 Package axi4_lite_pkg holds RESP_OKAY/RESP_ERR, data width 64, strobe width 8 and the RD_*/WR_* state encodings, shared with the interconnect.
REQ-037 Storage is sub-module axi4_lite_sram_array: one byte-enabled synchronous write port, one combinational read port.

Verification
REQ-038 Write 0x8000_0008 data 0x1122334455667788 strb 0xFF, B_READY = 1 -> B_VALID one cycle after commit, B_RESP = 0; read back gives 0x1122334455667788, R_RESP = 0.
REQ-039 W presented 3 cycles before AW, then strb 0x0F data 0xAAAAAAAAAAAAAAAA -> word reads 0x11223344AAAAAAAA.
REQ-040 RD_LATENCY = 4, AR handshake at cycle 0 -> R_VALID first high at cycle 4; R_READY held low 5 cycles -> R_DATA stable, AR_READY stays 0.
REQ-041 Read 0x7FFF_FFF8 and write 0x8000_2000 (DEPTH 1024) -> R_DATA = 0, R_RESP = 1; B_RESP = 1; memory unchanged.
REQ-042 Same-edge read capture and write commit on word 0x8000_0010 -> old data returned; rst_n pulsed low during RD_WAIT -> R_VALID stays 0, AR_READY high on first edge after release.
